// File: rtl/adc_sample_capture.sv
// ADC sample capture: detects rising edges of ADC_CLK in the clk domain,
// stores samples (free-run or level-triggered) into a buffer, then lets a
// host pop them out with 1-cycle read latency.
module adc_sample_capture #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ADC_CLK,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              start,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W:0]   num_samples,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_empty
);

  localparam int unsigned    DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_adc_clk_d;
  logic              w_tick;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   w_len_nxt;
  logic [ADDR_W:0]   r_wr_cnt;
  logic [ADDR_W:0]   w_wr_cnt_inc;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_prev_valid;
  logic [DATA_W-1:0] r_prev_smp;
  logic              w_trig_hit;
  logic              w_first_wr;
  logic              w_wr;
  logic              w_arm;
  logic              w_pop;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_tick       = ADC_CLK & ~r_adc_clk_d;
  assign w_trig_hit   = r_prev_valid && (r_prev_smp < trig_level) && (adc_data >= trig_level);
  assign w_first_wr   = (r_state == S_ARM) && w_tick && (!trig_en || w_trig_hit);
  assign w_wr         = w_first_wr || ((r_state == S_CAPTURE) && w_tick);
  assign w_wr_cnt_inc = r_wr_cnt + CNT_ONE;
  assign w_arm        = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_len_nxt    = ((num_samples == '0) || (num_samples > DEPTH_CNT)) ? DEPTH_CNT : num_samples;

  assign busy     = (r_state == S_ARM) || (r_state == S_CAPTURE);
  assign done     = (r_state == S_DONE);
  assign rd_empty = (r_state != S_DONE) || (r_rd_ptr == r_wr_cnt);
  // start in DONE re-arms and takes priority over a simultaneous pop
  assign w_pop    = (r_state == S_DONE) && rd_en && !start && !rd_empty;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; the first write in ARM and every write in CAPTURE
  // share the same "buffer full" test, which also covers len = 1
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_ARM;
      S_ARM:     if (w_first_wr) w_next = (w_wr_cnt_inc == r_len) ? S_DONE : S_CAPTURE;
      S_CAPTURE: if (w_wr && (w_wr_cnt_inc == r_len)) w_next = S_DONE;
      S_DONE:    if (start) w_next = S_ARM;
      default:   w_next = S_IDLE;
    endcase
  end

  // Counters, edge detector, trigger history and read-valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_adc_clk_d  <= 1'b0;
      r_len        <= '0;
      r_wr_cnt     <= '0;
      r_rd_ptr     <= '0;
      r_prev_valid <= 1'b0;
      r_prev_smp   <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_adc_clk_d <= ADC_CLK;
      r_rd_valid  <= w_pop;
      if (w_arm) begin
        r_len        <= w_len_nxt;
        r_wr_cnt     <= '0;
        r_rd_ptr     <= '0;
        r_prev_valid <= 1'b0;
      end else begin
        if (w_wr) r_wr_cnt <= w_wr_cnt_inc;
        if ((r_state == S_ARM) && w_tick && trig_en && !w_trig_hit) begin
          r_prev_smp   <= adc_data;
          r_prev_valid <= 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + CNT_ONE;
      end
    end
  end

  // Sample buffer write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_cnt[ADDR_W-1:0]] <= adc_data;
  end

  // Registered read port; data holds between pops
  always_ff @(posedge clk) begin
    if (reset)      r_rd_data <= '0;
    else if (w_pop) r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

endmodule
